// File: rtl/tipi_pkg.sv
// rtl/tipi_pkg.sv - shared constants and types for the TIPI transfer controller
//
// Purpose: TI-side register addresses, handshake FSM state encoding and
//          status byte bit positions used by tipi_xfer_ctrl.
// Ports:   none (package).

package tipi_pkg;

    localparam logic [15:0] ADDR_DATA   = 16'h5fff;  // TI write: data byte to RPi
    localparam logic [15:0] ADDR_CTRL   = 16'h5ffd;  // TI write: control byte, starts transfer
    localparam logic [15:0] ADDR_RDATA  = 16'h5ffb;  // TI read: RPi data byte
    localparam logic [15:0] ADDR_STATUS = 16'h5ff9;  // TI read: status byte

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int STAT_BUSY    = 7;
    localparam int STAT_OVERRUN = 6;
    localparam int STAT_TIMEOUT = 5;

endpackage

// File: rtl/tipi_sync.sv
// rtl/tipi_sync.sv - parameterized-width two-flop synchronizer
//
// Purpose: brings asynchronous inputs into the clk domain.
// Ports:   clk       system clock
//          rst_n     synchronous active-low reset (loads RESET_VAL)
//          d         asynchronous input bits
//          q         synchronized output bits

module tipi_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tipi_xfer_ctrl.sv
// rtl/tipi_xfer_ctrl.sv - TIPI TI<->RPi mailbox transfer controller
//
// Purpose: synchronizes TI bus strobes, latches TI writes to the data and
//          control registers, offers them to the RPi with a four-phase
//          valid/ack handshake, and returns RPi data / status on TI reads.
// Ports:   clk, rst_n                      clock, sync active-low reset
//          ti_a, ti_data                   TI address / write data (bit 0 = MSB)
//          ti_memen, ti_we, ti_reset       TI strobes, active low
//          ti_dbin                         TI read strobe, active high
//          tipi_data_out, tipi_control_out active-low read OEs (0x5ffb / 0x5ff9)
//          ti_rd_data                      byte to the TI bus transmitters
//          rpi_d, rpi_s, rpi_valid         latched data/control bytes and valid
//          rpi_ack, rpi_in                 RPi acknowledge and RPi-to-TI byte
//          busy                            FSM not in IDLE

module tipi_xfer_ctrl
    import tipi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:15] ti_a,
    input  logic [0:7]  ti_data,
    input  logic        ti_memen,
    input  logic        ti_we,
    input  logic        ti_reset,
    input  logic        ti_dbin,
    output logic        tipi_data_out,
    output logic        tipi_control_out,
    output logic [7:0]  ti_rd_data,
    output logic [7:0]  rpi_d,
    output logic [7:0]  rpi_s,
    output logic        rpi_valid,
    input  logic        rpi_ack,
    input  logic [7:0]  rpi_in,
    output logic        busy
);

    localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    ti_sync_q;
    logic          we_s, memen_s, tireset_s, dbin_s;
    logic          we_d;
    logic [8:0]    rpi_sync_q;
    logic          ack_s;
    logic [7:0]    rpi_in_s;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          overrun, timeout;
    logic          wr_ev, wr_data, wr_ctrl, tmo_hit, valid_next;
    logic [7:0]    status;
    logic          unused_dbin;

    tipi_sync #(.WIDTH(4), .RESET_VAL(4'b1110)) u_ti_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ti_we, ti_memen, ti_reset, ti_dbin}),
        .q     (ti_sync_q)
    );

    tipi_sync #(.WIDTH(9), .RESET_VAL(9'd0)) u_rpi_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({rpi_ack, rpi_in}),
        .q     (rpi_sync_q)
    );

    assign {we_s, memen_s, tireset_s, dbin_s} = ti_sync_q;
    assign {ack_s, rpi_in_s}                  = rpi_sync_q;
    // Synced DBIN is kept for symmetry with the other strobes; reads decode the raw bus.
    assign unused_dbin                        = dbin_s;

    // Edge-detect stage; like the synchronizers it is not cleared by TI reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_d <= 1'b1;
        end else begin
            we_d <= we_s;
        end
    end

    // Address and data are sampled raw: the TI holds them stable across the write.
    assign wr_ev   = we_d & ~we_s & ~memen_s;
    assign wr_data = wr_ev && (ti_a == ADDR_DATA);
    assign wr_ctrl = wr_ev && (ti_a == ADDR_CTRL);
    assign tmo_hit = (state != ST_IDLE) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!tireset_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (wr_ctrl) state_next = ST_PRESENT;
                ST_PRESENT: if (tmo_hit) state_next = ST_IDLE;
                            else if (ack_s) state_next = ST_RELEASE;
                ST_RELEASE: if (tmo_hit || !ack_s) state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Valid is registered and only set once PRESENT has held for a cycle, so it
    // rises the cycle after the latch and drops together with the exit from PRESENT.
    always_comb begin
        busy       = (state != ST_IDLE);
        valid_next = (state == ST_PRESENT) && (state_next == ST_PRESENT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !tireset_s) begin
            rpi_d     <= 8'h00;
            rpi_s     <= 8'h00;
            rpi_valid <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
        end else begin
            rpi_valid <= valid_next;
            cnt       <= (state_next != state || state == ST_IDLE) ? '0 : cnt + CW'(1);
            if (tmo_hit) begin
                timeout <= 1'b1;
            end
            // Writes are judged against the current state, so one landing on the
            // RELEASE->IDLE edge is still an overrun.
            if (wr_data) begin
                if (state == ST_IDLE) rpi_d   <= ti_data;
                else                  overrun <= 1'b1;
            end
            if (wr_ctrl) begin
                if (state == ST_IDLE) rpi_s   <= ti_data;
                else                  overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        status               = 8'h00;
        status[STAT_BUSY]    = busy;
        status[STAT_OVERRUN] = overrun;
        status[STAT_TIMEOUT] = timeout;
    end

    always_comb begin
        ti_rd_data = 8'h00;
        if (ti_a == ADDR_RDATA) begin
            ti_rd_data = rpi_in_s;
        end else if (ti_a == ADDR_STATUS) begin
            ti_rd_data = status;
        end
    end

    assign tipi_data_out    = ~(~ti_memen & ti_dbin & (ti_a == ADDR_RDATA));
    assign tipi_control_out = ~(~ti_memen & ti_dbin & (ti_a == ADDR_STATUS));

endmodule
